// File: rtl/key_cache.sv
// Fully-associative key cache in front of key memory: serves repeated key IDs
// from local entries, fetches misses, and answers stalled fetches with an error.
//
// state   | meaning
// IDLE    | waiting for key_req
// LOOKUP  | parallel tag compare of req_id against valid entries
// FETCH   | km_key_req pulse out, timeout counter loaded
// WAIT    | waiting for km_key_ack or timeout
// RESPOND | key_ack pulse out
module key_cache #(
  parameter int NUM_ENTRIES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk156,
  input  logic         areset_clk156,
  input  logic         key_req,
  input  logic [31:0]  key_id,
  output logic         key_ack,
  output logic [255:0] key,
  output logic         key_err,
  output logic         km_key_req,
  output logic [31:0]  km_key_id,
  input  logic         km_key_ack,
  input  logic [255:0] km_key,
  input  logic         flush,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [15:0]  timeout_count,
  output logic [15:0]  drop_count
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FETCH, S_WAIT, S_RESPOND
  } state_t;

  state_t               state;
  logic [NUM_ENTRIES-1:0] valid;
  logic [31:0]          entry_id  [NUM_ENTRIES];
  logic [255:0]         entry_key [NUM_ENTRIES];
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     victim_idx;
  logic                 hit;
  logic                 victim_is_valid;
  logic                 fill_en;
  logic [31:0]          req_id;
  logic [15:0]          to_cnt;
  logic                 flush_pending;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!hit && valid[i] && entry_id[i] == req_id) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid entry wins; fall back to the round-robin pointer.
  always_comb begin
    victim_idx      = rr_ptr;
    victim_is_valid = 1'b1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_idx      = IDX_W'(i);
        victim_is_valid = 1'b0;
      end
    end
  end

  assign fill_en = (state == S_WAIT) && km_key_ack && !flush_pending && !flush;

  always_ff @(posedge clk156) begin
    if (fill_en) begin
      entry_id[victim_idx]  <= req_id;
      entry_key[victim_idx] <= km_key;
    end
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state         <= S_IDLE;
      valid         <= '0;
      rr_ptr        <= '0;
      req_id        <= '0;
      to_cnt        <= '0;
      flush_pending <= 1'b0;
      key_ack       <= 1'b0;
      key           <= '0;
      key_err       <= 1'b0;
      km_key_req    <= 1'b0;
      km_key_id     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      timeout_count <= '0;
      drop_count    <= '0;
    end else begin
      key_ack    <= 1'b0;
      km_key_req <= 1'b0;

      if (key_req && state != S_IDLE)
        drop_count <= drop_count + 16'd1;

      if (flush)
        valid <= '0;
      else if (fill_en)
        valid[victim_idx] <= 1'b1;

      if (fill_en && victim_is_valid)
        rr_ptr <= rr_ptr + 1'b1;

      // A fill fetched across a flush may carry a stale key; return it but never cache it.
      if (flush && (state == S_FETCH || state == S_WAIT))
        flush_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (key_req) begin
            req_id <= key_id;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            key       <= entry_key[hit_idx];
            key_err   <= 1'b0;
            key_ack   <= 1'b1;
            hit_count <= hit_count + 32'd1;
            state     <= S_RESPOND;
          end else begin
            miss_count <= miss_count + 32'd1;
            km_key_req <= 1'b1;
            km_key_id  <= req_id;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          to_cnt <= TO_LOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (km_key_ack) begin
            key     <= km_key;
            key_err <= 1'b0;
            key_ack <= 1'b1;
            state   <= S_RESPOND;
          end else if (to_cnt == 16'd0) begin
            key           <= '0;
            key_err       <= 1'b1;
            key_ack       <= 1'b1;
            timeout_count <= timeout_count + 16'd1;
            state         <= S_RESPOND;
          end else begin
            to_cnt <= to_cnt - 16'd1;
          end
        end
        S_RESPOND: begin
          flush_pending <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_cache.sv
// Directed bench for key_cache: hit/miss latency, replacement order, timeout,
// flush during a fetch, busy drops and reset mid-fetch.
module tb_key_cache;

  localparam int NE = 4;
  localparam int TO = 16;

  logic         clk156 = 1'b0;
  logic         areset_clk156 = 1'b1;
  logic         key_req = 1'b0;
  logic [31:0]  key_id = '0;
  logic         key_ack;
  logic [255:0] key;
  logic         key_err;
  logic         km_key_req;
  logic [31:0]  km_key_id;
  logic         km_key_ack = 1'b0;
  logic [255:0] km_key = '0;
  logic         flush = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [15:0]  timeout_count;
  logic [15:0]  drop_count;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  key_cache #(.NUM_ENTRIES(NE), .TIMEOUT_CYCLES(TO)) dut (
    .clk156(clk156), .areset_clk156(areset_clk156),
    .key_req(key_req), .key_id(key_id),
    .key_ack(key_ack), .key(key), .key_err(key_err),
    .km_key_req(km_key_req), .km_key_id(km_key_id),
    .km_key_ack(km_key_ack), .km_key(km_key),
    .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count),
    .timeout_count(timeout_count), .drop_count(drop_count)
  );

  always #5 clk156 = ~clk156;
  always @(posedge clk156) cyc <= cyc + 1;

  function automatic logic [255:0] kv(input logic [31:0] id);
    if (id == 32'd7) return {32{8'hAA}};
    return {8{32'hC0DE0000 ^ id}};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_counters(input string tag, input int h, input int m, input int t, input int d);
    check({tag, "/hit_count"},     hit_count,     h);
    check({tag, "/miss_count"},    miss_count,    m);
    check({tag, "/timeout_count"}, timeout_count, t);
    check({tag, "/drop_count"},    drop_count,    d);
  endtask

  // One request with a keymem responder; ack_delay<0 means keymem never answers.
  task automatic transact(input logic [31:0] id, input int ack_delay, input int flush_off,
                          input bit exp_hit, input logic [255:0] exp_key, input bit exp_err,
                          input string tag);
    int t0, r, a, nreq, t_ack, exp_t;
    r = -1; a = -1; nreq = 0; t_ack = -1;
    @(negedge clk156);
    key_req = 1'b1; key_id = id; t0 = cyc;
    for (int n = 0; n < 64 && t_ack < 0; n++) begin
      @(negedge clk156);
      key_req = 1'b0; km_key_ack = 1'b0; flush = 1'b0;
      if (km_key_req) begin
        nreq++; r = cyc;
        check({tag, "/km_key_id"}, km_key_id, id);
      end
      if (r >= 0 && ack_delay >= 0 && cyc == r + ack_delay) begin
        km_key_ack = 1'b1; km_key = kv(id); a = cyc;
      end
      if (r >= 0 && flush_off >= 0 && cyc == r + flush_off) flush = 1'b1;
      if (key_ack) t_ack = cyc;
    end
    km_key_ack = 1'b0; flush = 1'b0;
    if (exp_hit) begin
      exp_t = t0 + 2;
      check({tag, "/km_req_cnt"}, nreq, 0);
    end else begin
      exp_t = (ack_delay >= 0) ? a + 1 : t0 + 3 + TO;
      check({tag, "/km_req_cnt"}, nreq, 1);
      check({tag, "/km_req_cyc"}, r, t0 + 2);
    end
    check({tag, "/ack_cyc"}, t_ack, exp_t);
    check({tag, "/key"}, key, exp_key);
    check({tag, "/key_err"}, key_err, exp_err);
    @(negedge clk156);
    check({tag, "/ack_pulse"}, key_ack, 1'b0);
    check({tag, "/key_held"}, key, exp_key);
  endtask

  task automatic pulse_flush();
    @(negedge clk156); flush = 1'b1;
    @(negedge clk156); flush = 1'b0;
  endtask

  initial begin
    int t0, extra;
    repeat (3) @(negedge clk156);
    check("rst/key_ack", key_ack, 1'b0);
    check("rst/key", key, '0);
    check("rst/key_err", key_err, 1'b0);
    check("rst/km_key_req", km_key_req, 1'b0);
    check("rst/km_key_id", km_key_id, '0);
    check_counters("rst", 0, 0, 0, 0);
    areset_clk156 = 1'b0;

    transact(32'd7, 5, -1, 1'b0, kv(32'd7), 1'b0, "cold_miss");
    check_counters("cold_miss", 0, 1, 0, 0);
    transact(32'd7, 2, -1, 1'b1, kv(32'd7), 1'b0, "hit7");
    check_counters("hit7", 1, 1, 0, 0);

    // Replacement: entries 0..3 = 1,2,3,4, then 5 evicts 1, 1 evicts 2, 2 evicts 3.
    pulse_flush();
    transact(32'd1, 3, -1, 1'b0, kv(32'd1), 1'b0, "fill1");
    transact(32'd2, 3, -1, 1'b0, kv(32'd2), 1'b0, "fill2");
    transact(32'd3, 3, -1, 1'b0, kv(32'd3), 1'b0, "fill3");
    transact(32'd4, 3, -1, 1'b0, kv(32'd4), 1'b0, "fill4");
    transact(32'd5, 3, -1, 1'b0, kv(32'd5), 1'b0, "miss5");
    transact(32'd1, 3, -1, 1'b0, kv(32'd1), 1'b0, "remiss1");
    transact(32'd3, 2, -1, 1'b1, kv(32'd3), 1'b0, "hit3");
    transact(32'd2, 3, -1, 1'b0, kv(32'd2), 1'b0, "remiss2");
    check_counters("repl", 2, 8, 0, 0);

    transact(32'h55, -1, -1, 1'b0, '0, 1'b1, "timeout");
    check_counters("timeout", 2, 9, 1, 0);
    @(negedge clk156); km_key_ack = 1'b1; km_key = kv(32'hDEAD);
    @(negedge clk156); km_key_ack = 1'b0;
    transact(32'h55, 2, -1, 1'b0, kv(32'h55), 1'b0, "after_timeout");

    transact(32'd9, 6, 2, 1'b0, kv(32'd9), 1'b0, "flush_wait");
    transact(32'd9, 1, -1, 1'b0, kv(32'd9), 1'b0, "post_flush9");
    transact(32'd5, 2, -1, 1'b0, kv(32'd5), 1'b0, "post_flush5");
    transact(32'h55, 2, -1, 1'b0, kv(32'h55), 1'b0, "post_flush55");
    check_counters("flush", 2, 14, 1, 0);

    // Back-to-back requests: second one lands in LOOKUP and is dropped.
    @(negedge clk156); key_req = 1'b1; key_id = 32'd9; t0 = cyc;
    @(negedge clk156); key_id = 32'h77;
    @(negedge clk156); key_req = 1'b0;
    check("busy/ack_cyc", key_ack, 1'b1);
    check("busy/key", key, kv(32'd9));
    extra = 0;
    repeat (6) begin
      @(negedge clk156);
      if (key_ack || km_key_req) extra++;
    end
    check("busy/extra_activity", extra, 0);
    check_counters("busy", 3, 14, 1, 1);

    // Async reset while waiting on keymem.
    @(negedge clk156); key_req = 1'b1; key_id = 32'h88;
    @(negedge clk156); key_req = 1'b0;
    repeat (4) @(negedge clk156);
    check("rstwait/km_key_id", km_key_id, 32'h88);
    #2 areset_clk156 = 1'b1;
    #1;
    check("rstwait/key", key, '0);
    check("rstwait/key_ack", key_ack, 1'b0);
    check("rstwait/km_key_id", km_key_id, '0);
    check_counters("rstwait", 0, 0, 0, 0);
    @(negedge clk156); areset_clk156 = 1'b0;
    transact(32'd9, 2, -1, 1'b0, kv(32'd9), 1'b0, "post_rst");
    check_counters("post_rst", 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_cache.md
Name: key_cache

Overview:
- Small fully-associative key cache between a network path's key request port and its key memory, both in the clk156 domain.
- Serves repeated requests for recently used key IDs in 2 cycles without a key-memory round trip.
- Forwards misses to key memory, fills the cache with the returned key, and times out stalled fetches.
- Software-visible hit/miss/timeout counters; flush input invalidates all entries when keys are rewritten.

Parameters:
- NUM_ENTRIES, 4, number of cache entries; power of two, 2..16.
- TIMEOUT_CYCLES, 1024, max clk156 cycles waiting for km_key_ack before error response; 16-bit counter.

Ports:
- clk156  input  1  block clock.
- areset_clk156  input  1  asynchronous active-high reset.
- key_req  input  1  single-cycle request pulse from network path.
- key_id  input  32  requested key ID, sampled with key_req.
- key_ack  output  1  single-cycle response pulse.
- key  output  256  key value, valid with key_ack, held until the next key_ack.
- key_err  output  1  high with key_ack when the fetch timed out (key = 0); held like key.
- km_key_req  output  1  single-cycle fetch pulse to key memory.
- km_key_id  output  32  fetch key ID, held stable from km_key_req until the fetch ends.
- km_key_ack  input  1  single-cycle fetch response pulse.
- km_key  input  256  fetched key, valid with km_key_ack.
- flush  input  1  single-cycle pulse; invalidates all entries.
- hit_count  output  32  wrapping count of hits.
- miss_count  output  32  wrapping count of misses.
- timeout_count  output  16  wrapping count of timeouts.
- drop_count  output  16  wrapping count of key_req pulses ignored while busy.

Behaviour:
- Reset (async assert, sync release):
  - key_ack, key_err, km_key_req = 0; key, km_key_id = 0.
  - All valid bits = 0; replacement pointer = 0; all counters = 0; FSM = IDLE.
- FSM states: IDLE, LOOKUP, FETCH, WAIT, RESPOND.
- IDLE: key_req=1 latches key_id into req_id -> LOOKUP.
- LOOKUP: compare req_id against all valid entries in parallel.
  - Hit: load key from the entry; hit_count+1; -> RESPOND.
  - Miss: miss_count+1; -> FETCH.
- FETCH: km_key_req=1 for exactly one cycle; km_key_id=req_id; clear the timeout counter; -> WAIT.
- WAIT:
  - km_key_ack=1: key <= km_key, key_err <= 0; write {req_id, km_key} into the victim entry and set valid, unless a flush occurred during this fetch; -> RESPOND.
  - Counter reaches TIMEOUT_CYCLES-1 without km_key_ack: key <= 0, key_err <= 1, timeout_count+1, no write; -> RESPOND.
- RESPOND: key_ack=1 for one cycle -> IDLE.
- Latency:
  - Hit: key_req at cycle T -> key_ack at T+2.
  - Miss: km_key_req at T+2; km_key_ack at cycle A -> key_ack at A+1.
  - Timeout: key_ack at T+3+TIMEOUT_CYCLES.
- Victim selection: lowest-index invalid entry if any exists, else the entry at the round-robin pointer. The pointer increments mod NUM_ENTRIES only when a valid entry is evicted.
- Duplicate IDs never coexist: a fill only follows a miss, and the flush-guard prevents stale writes.
- key_req in any state other than IDLE: ignored, drop_count+1; no other effect.
- km_key_ack outside WAIT (late ack after timeout): ignored, no write.
- flush:
  - Clears all valid bits at the next edge; does not reset the pointer or counters.
  - flush with key_req in IDLE: the request proceeds and LOOKUP sees all entries invalid (miss).
  - flush during LOOKUP: a same-cycle hit is still served from the old entry (lookup reads the pre-flush state).
  - flush in FETCH/WAIT sets a flush_pending flag: the fill is still returned to the requester but not written. flush_pending clears on entry to IDLE.
- Counter width rule: all counters wrap to 0 on overflow, no saturation.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- Cold miss: reset, key_req with key_id=0x00000007; keymem returns km_key=0xAA..AA 5 cycles after km_key_req -> km_key_req at T+2 with km_key_id=7; key_ack 1 cycle after km_key_ack with key=0xAA..AA, key_err=0; miss_count=1.
- Hit: repeat key_id=7 -> key_ack exactly at T+2, no km_key_req, key=0xAA..AA; hit_count=1.
- Replacement: NUM_ENTRIES=4; fill IDs 1,2,3,4, then miss on 5 evicts ID 1 (pointer 0->1) -> next request for 1 misses and evicts ID 2; request for 3 hits.
- Timeout: TIMEOUT_CYCLES=16, keymem never acks -> key_ack at T+19 with key=0, key_err=1; timeout_count=1; later km_key_ack ignored; subsequent request for the same ID misses.
- Flush during WAIT: miss on ID 9, pulse flush, then km_key_ack -> key_ack with the fetched key; next request for ID 9 misses; all prior entries miss.
- Busy drop: key_req pulses at T and T+1 -> only the first served, drop_count=1; async reset asserted in WAIT -> outputs 0 immediately, FSM IDLE, cache empty.
